video_mixer: RTL and testbench

- Pixel-clock stage between the display timing generator and the DVI/TMDS transmitter.
- Derives its own active-area x/y counters from incoming hs/vs/de.
- Generates a 16-bar test pattern and selects per frame between pattern, camera RGB565 and a split view.
- Outputs delay-matched sync and RGB888 for the TMDS encoder.

---
 rtl/video_pkg.sv | 32 +++
 rtl/video_mixer_if.sv | 33 +++
 rtl/video_pos_counter.sv | 103 ++++++++++
 rtl/video_mixer.sv | 103 ++++++++++
 tb/tb_video_mixer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared types for the video mixer.
//   mode_e         - per-frame output mode encodings
//   rgb565_t       - camera / internal colour word {r5,g6,b5}
//   rgb888_t       - TMDS-side colour {r8,g8,b8}
//   rgb565_to_888  - channel expansion by MSB replication
package video_pkg;

  typedef enum logic [1:0] {
    MODE_SPLIT = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CAM   = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicating the top bits keeps full-scale at 8'hFF and zero at 8'h00.
  function automatic rgb888_t rgb565_to_888(rgb565_t c);
    rgb888_t o;
    o.r = {c[15:11], c[15:13]};
    o.g = {c[10:5],  c[10:9]};
    o.b = {c[4:0],   c[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/video_mixer_if.sv
// video_mixer_if: timing-generator inputs, camera pixel, control and the
// delay-matched RGB888 stream towards the TMDS encoder.
//   master - drives hs_i/vs_i/de_i/cam_rgb/mode_sel/err_clr, observes outputs
//   slave  - the mixer: consumes the inputs, drives hs_o/vs_o/de_o/r_o/g_o/b_o,
//            mode_cur and line_err
interface video_mixer_if;
  import video_pkg::*;

  logic       hs_i;
  logic       vs_i;
  logic       de_i;
  rgb565_t    cam_rgb;
  logic [1:0] mode_sel;
  logic       err_clr;
  logic       hs_o;
  logic       vs_o;
  logic       de_o;
  logic [7:0] r_o;
  logic [7:0] g_o;
  logic [7:0] b_o;
  logic [1:0] mode_cur;
  logic       line_err;

  modport master (
    output hs_i, vs_i, de_i, cam_rgb, mode_sel, err_clr,
    input  hs_o, vs_o, de_o, r_o, g_o, b_o, mode_cur, line_err
  );

  modport slave (
    input  hs_i, vs_i, de_i, cam_rgb, mode_sel, err_clr,
    output hs_o, vs_o, de_o, r_o, g_o, b_o, mode_cur, line_err
  );
endinterface

// File: rtl/video_pos_counter.sv
// video_pos_counter: active-area position tracking derived from de/vs.
//   clk, rst_n   - pixel clock, asynchronous active-low reset
//   vs_i, de_i   - timing generator vertical sync and data enable
//   err_clr_i    - single-cycle clear of line_err_o
//   x_hi_o       - x[10:5] of the pixel now in stage 1 (x saturates at H_ACTIVE-1)
//   y_o          - active line index, saturates at V_ACTIVE-1
//   bar_idx_o    - colour-bar index 0..15 of the pixel in stage 1
//   vs_lead_o    - vs_i is entering its active level this cycle
//   line_err_o   - sticky: some line had a de run length other than H_ACTIVE
module video_pos_counter #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned BAR_W    = 80,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic        err_clr_i,
  output logic [5:0]  x_hi_o,
  output logic [10:0] y_o,
  output logic [3:0]  bar_idx_o,
  output logic        vs_lead_o,
  output logic        line_err_o
);

  logic        de_q, vs_q;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [3:0]  bar_idx_q, bar_idx_d;
  logic [11:0] run_q, run_d;
  logic        err_q, err_d;
  logic        de_fall, vs_lead;

  assign vs_lead = (vs_i == VS_POL) && (vs_q != VS_POL);
  assign de_fall = de_q && !de_i;

  always_comb begin
    x_d       = '0;
    bar_cnt_d = '0;
    bar_idx_d = '0;
    // First de cycle of a line leaves everything at 0.
    if (de_i && de_q) begin
      x_d = (x_q == 11'(H_ACTIVE - 1)) ? x_q : x_q + 11'd1;
      if (bar_cnt_q == 11'(BAR_W - 1)) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 4'd15) ? bar_idx_q : bar_idx_q + 4'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 11'd1;
        bar_idx_d = bar_idx_q;
      end
    end

    // At a de falling edge run_q holds the full length of the line just ended.
    run_d = de_i ? run_q + 12'd1 : '0;

    y_d = y_q;
    if (vs_lead) begin
      y_d = '0;
    end else if (de_fall && (y_q != 11'(V_ACTIVE - 1))) begin
      y_d = y_q + 11'd1;
    end

    err_d = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (de_fall && (run_q != 12'(H_ACTIVE))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q      <= 1'b0;
      vs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      run_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      de_q      <= de_i;
      vs_q      <= vs_i;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  assign x_hi_o     = x_q[10:5];
  assign y_o        = y_q;
  assign bar_idx_o  = bar_idx_q;
  assign vs_lead_o  = vs_lead;
  assign line_err_o = err_q;

endmodule

// File: rtl/video_mixer.sv
// video_mixer: two-stage pixel pipeline between timing generator and TMDS.
//   clk, rst_n - pixel clock, asynchronous active-low reset
//   vid        - video_mixer_if.slave: hs_i/vs_i/de_i/cam_rgb/mode_sel/err_clr in;
//                hs_o/vs_o/de_o (2-cycle delayed), r_o/g_o/b_o (RGB888),
//                mode_cur (mode latched at vs leading edge), line_err out
// Stage 1 registers sync, camera pixel and position; stage 2 registers the
// selected, expanded colour (forced to 0 outside de).
module video_mixer
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned SPLIT_Y  = 360,
  parameter int unsigned BAR_W    = 80,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  video_mixer_if.slave   vid
);

  logic        hs1_q, vs1_q, de1_q;
  rgb565_t     cam1_q;
  logic        hs2_q, vs2_q, de2_q;
  rgb888_t     pix2_q, pix_d;
  mode_e       mode_q, mode_d;
  logic [5:0]  x_hi;
  logic [10:0] y;
  logic [3:0]  bar_idx;
  logic        vs_lead;
  rgb565_t     bar_c, ramp_c, sel_c;

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BAR_W    (BAR_W),
    .VS_POL   (VS_POL)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs_i       (vid.vs_i),
    .de_i       (vid.de_i),
    .err_clr_i  (vid.err_clr),
    .x_hi_o     (x_hi),
    .y_o        (y),
    .bar_idx_o  (bar_idx),
    .vs_lead_o  (vs_lead),
    .line_err_o (vid.line_err)
  );

  // Mode only moves at the frame boundary, so a frame is never mixed.
  always_comb begin
    mode_d = mode_q;
    if (vs_lead) begin
      mode_d = mode_e'(vid.mode_sel);
    end
  end

  always_comb begin
    bar_c  = rgb565_t'(16'h8000 >> bar_idx);
    ramp_c = {x_hi[5:1], x_hi, x_hi[5:1]};
    case (mode_q)
      MODE_SPLIT: sel_c = (y > 11'(SPLIT_Y)) ? cam1_q : bar_c;
      MODE_BARS:  sel_c = bar_c;
      MODE_CAM:   sel_c = cam1_q;
      default:    sel_c = ramp_c;
    endcase
    pix_d = de1_q ? rgb565_to_888(sel_c) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
      cam1_q <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      de2_q  <= 1'b0;
      pix2_q <= '0;
      mode_q <= MODE_SPLIT;
    end else begin
      hs1_q  <= vid.hs_i;
      vs1_q  <= vid.vs_i;
      de1_q  <= vid.de_i;
      cam1_q <= vid.cam_rgb;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= de1_q;
      pix2_q <= pix_d;
      mode_q <= mode_d;
    end
  end

  assign vid.hs_o     = hs2_q;
  assign vid.vs_o     = vs2_q;
  assign vid.de_o     = de2_q;
  assign vid.r_o      = pix2_q.r;
  assign vid.g_o      = pix2_q.g;
  assign vid.b_o      = pix2_q.b;
  assign vid.mode_cur = mode_q;

endmodule

// File: tb/tb_video_mixer.sv
`timescale 1ns/1ps
module tb_video_mixer;

  localparam int unsigned H     = 1280;
  localparam int unsigned V     = 4;
  localparam int unsigned SPLIT = 1;
  localparam int unsigned BW    = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_mixer_if vif();

  video_mixer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .SPLIT_Y  (SPLIT),
    .BAR_W    (BW),
    .VS_POL   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus side ----------------
  int          drv_x = -1;
  int          drv_y = 0;
  int          drv_tag = 0;
  logic [15:0] cam_base = 16'h0;
  bit          cam_vary = 1'b0;

  task automatic drive(input logic hs, input logic vs, input logic de, input int x, input logic clr);
    @(posedge clk); #1;
    vif.hs_i    = hs;
    vif.vs_i    = vs;
    vif.de_i    = de;
    vif.err_clr = clr;
    vif.cam_rgb = de ? (cam_base ^ (cam_vary ? 16'(x * 7) : 16'h0)) : 16'hDEAD;
    drv_x       = de ? x : -1;
  endtask

  task automatic vsync();
    drv_y = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic line(input int len, input logic clr_at_end);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < len; i++) drive(1'b0, 1'b0, 1'b1, i, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, clr_at_end);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drv_y++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       hs, vs, de;
    logic [7:0] r, g, b;
    int         x, y, tag;
  } exp_t;

  exp_t        e_pipe, e_out, e_new;
  int          m_run, m_y, m_px;
  logic [1:0]  m_mode;
  logic        m_err, m_vs_prev, m_de_prev, m_lead, m_fall;
  logic [15:0] m_c;

  function automatic logic [15:0] pick(input int mode, input int px, input int py, input logic [15:0] cam);
    int bar;
    bar = px / int'(BW);
    if (bar > 15) bar = 15;
    case (mode)
      0:       return (py > int'(SPLIT)) ? cam : 16'(32'h8000 >> bar);
      1:       return 16'(32'h8000 >> bar);
      2:       return cam;
      default: return 16'(((px / 64) << 11) | ((px / 32) << 5) | (px / 64));
    endcase
  endfunction

  function automatic logic [7:0] widen5(input int v);
    return 8'((v << 3) | (v >> 2));
  endfunction

  function automatic logic [7:0] widen6(input int v);
    return 8'((v << 2) | (v >> 4));
  endfunction

  function automatic exp_t zero_exp();
    exp_t z;
    z.hs = 0; z.vs = 0; z.de = 0; z.r = 0; z.g = 0; z.b = 0;
    z.x = -1; z.y = 0; z.tag = 0;
    return z;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e_pipe    = zero_exp();
      e_out     = zero_exp();
      m_run     = 0;
      m_y       = 0;
      m_mode    = 2'd0;
      m_err     = 1'b0;
      m_vs_prev = 1'b0;
      m_de_prev = 1'b0;
    end else begin
      m_lead = vif.vs_i && !m_vs_prev;
      m_fall = m_de_prev && !vif.de_i;
      if (vif.err_clr) m_err = 1'b0;
      if (m_fall && m_run != int'(H)) m_err = 1'b1;
      if (m_lead) begin
        m_mode = vif.mode_sel;
        m_y    = 0;
      end else if (m_fall && m_y < int'(V) - 1) begin
        m_y++;
      end
      e_new     = zero_exp();
      e_new.hs  = vif.hs_i;
      e_new.vs  = vif.vs_i;
      e_new.de  = vif.de_i;
      e_new.x   = drv_x;
      e_new.y   = drv_y;
      e_new.tag = drv_tag;
      if (vif.de_i) begin
        m_px    = (m_run < int'(H) - 1) ? m_run : int'(H) - 1;
        m_c     = pick(int'(m_mode), m_px, m_y, vif.cam_rgb);
        e_new.r = widen5(int'(m_c[15:11]));
        e_new.g = widen6(int'(m_c[10:5]));
        e_new.b = widen5(int'(m_c[4:0]));
      end
      m_run     = vif.de_i ? m_run + 1 : 0;
      m_de_prev = vif.de_i;
      m_vs_prev = vif.vs_i;
      e_out     = e_pipe;
      e_pipe    = e_new;
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    check("hs_o",     vif.hs_o,     e_out.hs);
    check("vs_o",     vif.vs_o,     e_out.vs);
    check("de_o",     vif.de_o,     e_out.de);
    check("r_o",      vif.r_o,      e_out.r);
    check("g_o",      vif.g_o,      e_out.g);
    check("b_o",      vif.b_o,      e_out.b);
    check("mode_cur", vif.mode_cur, m_mode);
    check("line_err", vif.line_err, m_err);
    // Hand-computed pins on specific pixels.
    if (e_out.x >= 0) begin
      if (e_out.tag == 1) begin
        if (e_out.x == 0) begin
          check("lag_de", vif.de_o, 1'b1);
          check("bar0_r", vif.r_o, 8'h84);
        end
        if (e_out.x == 80)   check("bar1_r",  vif.r_o, 8'h42);
        if (e_out.x == 1200) check("bar15_b", vif.b_o, 8'h08);
        if (e_out.x == 1279) check("bar15_r", vif.r_o, 8'h00);
      end
      if (e_out.tag == 2 && e_out.x == 5) begin
        if (e_out.y <= int'(SPLIT)) begin
          check("split_top_r", vif.r_o, 8'h84);
        end else begin
          check("split_cam_r", vif.r_o, 8'hFF);
          check("split_cam_g", vif.g_o, 8'hFF);
          check("split_cam_b", vif.b_o, 8'hFF);
        end
      end
      if (e_out.tag == 3 && e_out.x == 0 && e_out.y == 0) begin
        check("cam_r", vif.r_o, 8'h10);
        check("cam_g", vif.g_o, 8'h45);
        check("cam_b", vif.b_o, 8'hA5);
      end
      if (e_out.tag == 4) begin
        if (e_out.x == 64) begin
          check("ramp64_r", vif.r_o, 8'h08);
          check("ramp64_g", vif.g_o, 8'h08);
        end
        if (e_out.x == 1279) begin
          check("ramp1279_r", vif.r_o, 8'h9C);
          check("ramp1279_g", vif.g_o, 8'h9E);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_hs"},   vif.hs_o,     1'b0);
    check({tag, "_vs"},   vif.vs_o,     1'b0);
    check({tag, "_de"},   vif.de_o,     1'b0);
    check({tag, "_r"},    vif.r_o,      8'h00);
    check({tag, "_g"},    vif.g_o,      8'h00);
    check({tag, "_b"},    vif.b_o,      8'h00);
    check({tag, "_mode"}, vif.mode_cur, 2'd0);
    check({tag, "_err"},  vif.line_err, 1'b0);
  endtask

  initial begin
    vif.hs_i     = 1'b0;
    vif.vs_i     = 1'b0;
    vif.de_i     = 1'b0;
    vif.cam_rgb  = 16'h0;
    vif.mode_sel = 2'd1;
    vif.err_clr  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Bars, two frames.
    drv_tag = 1; cam_base = 16'h5A5A; cam_vary = 1'b1; vif.mode_sel = 2'd1;
    vsync(); for (int l = 0; l < int'(V); l++) line(int'(H), 1'b0);
    vsync(); for (int l = 0; l < int'(V); l++) line(int'(H), 1'b0);

    // Split view with a white camera.
    drv_tag = 2; cam_base = 16'hFFFF; cam_vary = 1'b0; vif.mode_sel = 2'd0;
    vsync(); for (int l = 0; l < int'(V); l++) line(int'(H), 1'b0);

    // Mode request mid-frame takes effect only at the next frame.
    drv_tag = 0; cam_base = 16'h1234; cam_vary = 1'b1; vif.mode_sel = 2'd1;
    vsync(); line(int'(H), 1'b0); line(int'(H), 1'b0);
    vif.mode_sel = 2'd2;
    line(int'(H), 1'b0);
    check("mode_hold", vif.mode_cur, 2'd1);
    line(int'(H), 1'b0);
    drv_tag = 3;
    vsync();
    check("mode_switch", vif.mode_cur, 2'd2);
    line(int'(H), 1'b0); line(int'(H), 1'b0);

    // Line length error, stickiness, clear, and set-beats-clear.
    drv_tag = 0;
    line(int'(H), 1'b0);
    check("err_good_line", vif.line_err, 1'b0);
    line(int'(H) - 1, 1'b0);
    check("err_set", vif.line_err, 1'b1);
    line(int'(H), 1'b0);
    check("err_sticky", vif.line_err, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("err_clr", vif.line_err, 1'b0);
    line(int'(H) - 1, 1'b1);
    check("err_set_wins", vif.line_err, 1'b1);

    // Asynchronous reset in the middle of a line.
    vif.mode_sel = 2'd1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 500; i++) drive(1'b0, 1'b0, 1'b1, i, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    drv_tag = 1; cam_vary = 1'b1; cam_base = 16'h0F0F;
    vsync(); for (int l = 0; l < int'(V); l++) line(int'(H), 1'b0);

    // Grey ramp.
    drv_tag = 4; vif.mode_sel = 2'd3;
    vsync(); line(int'(H), 1'b0); line(int'(H), 1'b0);

    drv_tag = 0;
    repeat (4) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
